// File: rtl/reset_sync_seq_if.sv
// rtl/reset_sync_seq_if.sv - reset sequencer request/status bundle
interface reset_sync_seq_if #(
    parameter int NUM_OUT = 4
);
    logic               sw_rst_req;
    logic [NUM_OUT-1:0] valid;
    logic               all_valid;
    logic               busy;

    modport master (
        output sw_rst_req,
        input  valid,
        input  all_valid,
        input  busy
    );

    modport slave (
        input  sw_rst_req,
        output valid,
        output all_valid,
        output busy
    );
endinterface

// File: rtl/reset_sync_seq.sv
// rtl/reset_sync_seq.sv - async-assert/sync-release reset with staggered per-output release
module reset_sync_seq #(
    parameter int STAGES      = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int NUM_OUT     = 4,
    parameter int STAGGER     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    reset_sync_seq_if.slave  bus
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int STG_W  = $clog2(STAGGER + 1);
    localparam int IDX_W  = $clog2(NUM_OUT + 1);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    logic [STAGES-1:0]  sync_q;
    logic               sync_out;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [STG_W-1:0]   stg_q, stg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] valid_q, valid_d;
    logic               all_valid_q;
    logic               busy_q;
    logic               restart;
    logic               release0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign sync_out = sync_q[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SYNC;
            hold_q      <= '0;
            stg_q       <= '0;
            idx_q       <= '0;
            valid_q     <= '0;
            all_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stg_q       <= stg_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            all_valid_q <= (state_d == ST_RUN);
            busy_q      <= (state_d != ST_RUN);
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        stg_d    = stg_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        restart  = 1'b0;
        release0 = 1'b0;

        case (state_q)
            // The FSM sees the chain output one edge after it settles, so the
            // first SYNC cycle with sync_out high already counts as HOLD cycle one.
            ST_SYNC: begin
                if (sync_out) begin
                    if (bus.sw_rst_req) begin
                        restart = 1'b1;
                    end else if (HOLD_CYCLES == 1) begin
                        release0 = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (bus.sw_rst_req) begin
                    restart = 1'b1;
                end else if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    release0 = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (bus.sw_rst_req) begin
                    restart = 1'b1;
                end else if (stg_q == STG_W'(STAGGER - 1)) begin
                    valid_d = valid_q | (NUM_OUT'(1) << idx_q);
                    stg_d   = '0;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_W'(NUM_OUT - 1)) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    stg_d = stg_q + 1'b1;
                end
            end
            default: begin
                if (bus.sw_rst_req) begin
                    restart = 1'b1;
                end
            end
        endcase

        if (release0) begin
            valid_d = NUM_OUT'(1);
            stg_d   = '0;
            idx_d   = IDX_W'(1);
            state_d = (NUM_OUT == 1) ? ST_RUN : ST_RELEASE;
        end

        if (restart) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            stg_d   = '0;
            idx_d   = '0;
            valid_d = '0;
        end
    end

    assign bus.valid     = valid_q;
    assign bus.all_valid = all_valid_q;
    assign bus.busy      = busy_q;
endmodule
